// File: rtl/matmul_engine.sv
// matmul_engine: N x N unsigned matrix multiply C = A x B.
// A and B are read from a single-port synchronous SRAM, both stored row-major.
// C is streamed row-major over a valid/ready result port that supports backpressure.
// Optional build macro MATMUL_SAT_EN: clamp res_data to all-ones when the
// accumulator exceeds OW bits. Without it, res_data keeps the low OW bits.

module matmul_engine #(
   parameter int unsigned N      = 4,
   parameter int unsigned DW     = 8,
   parameter int unsigned SW     = 18,
   parameter int unsigned AW     = 11,
   parameter int unsigned BASE_A = 0,
   parameter int unsigned BASE_B = 16,
   parameter int unsigned OW     = 18
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   sram_en,
   output logic [AW-1:0]          sram_addr,
   input  logic [SW-1:0]          sram_rdata,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [OW-1:0]          res_data,
   output logic [$clog2(N)-1:0]   res_row,
   output logic [$clog2(N)-1:0]   res_col
);

   localparam int unsigned IW    = $clog2(N);
   localparam int unsigned ACC_W = 2 * DW + $clog2(N);
   localparam int unsigned WW    = (ACC_W > OW) ? ACC_W : OW;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_A,
      S_RD_B,
      S_MAC,
      S_EMIT,
      S_DONE
   } state_t;

   state_t              state;
   logic [IW-1:0]       i;
   logic [IW-1:0]       j;
   logic [IW-1:0]       k;
   logic [ACC_W-1:0]    acc;
   logic [DW-1:0]       a_reg;

   logic [DW-1:0]       rd_lo;
   logic [2*DW-1:0]     prod;
   logic [ACC_W-1:0]    acc_sum;
   logic [IW-1:0]       i_next;
   logic [IW-1:0]       j_next;
   logic                last_elem;

   // Only the low DW bits of an SRAM word are operand data.
   logic                unused_rdata;
   assign unused_rdata = ^sram_rdata;

   // Word address base + row*N + col, wrapping modulo 2^AW.
   function automatic logic [AW-1:0] word_addr(input int unsigned base,
                                               input logic [IW-1:0] row,
                                               input logic [IW-1:0] col);
      int unsigned sum;
      sum = base + 32'(row) * N + 32'(col);
      return AW'(sum);
   endfunction

   // Map the full-precision accumulator onto the OW-bit result bus.
   function automatic logic [OW-1:0] shape(input logic [ACC_W-1:0] v);
      logic [WW-1:0] w;
      w = WW'(v);
`ifdef MATMUL_SAT_EN
      if (w > WW'({OW{1'b1}})) begin
         w = WW'({OW{1'b1}});
      end
`endif
      return OW'(w);
   endfunction

   // Datapath arithmetic and index stepping used by the sequencer.
   always_comb begin
      rd_lo     = sram_rdata[DW-1:0];
      prod      = a_reg * rd_lo;
      acc_sum   = acc + ACC_W'(prod);
      j_next    = (j == LAST) ? '0 : j + IW'(1);
      i_next    = (j != LAST) ? i : ((i == LAST) ? '0 : i + IW'(1));
      last_elem = (i == LAST) && (j == LAST);
   end

   // Sequencer: every output is registered and set on entry to the state that owns it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         i         <= '0;
         j         <= '0;
         k         <= '0;
         acc       <= '0;
         a_reg     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sram_en   <= 1'b0;
         sram_addr <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_row   <= '0;
         res_col   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  i         <= '0;
                  j         <= '0;
                  k         <= '0;
                  acc       <= '0;
                  busy      <= 1'b1;
                  sram_en   <= 1'b1;
                  sram_addr <= word_addr(BASE_A, '0, '0);
                  state     <= S_RD_A;
               end
            end
            S_RD_A: begin
               // A word is in flight; present the B address so B lands in MAC.
               sram_addr <= word_addr(BASE_B, k, j);
               state     <= S_RD_B;
            end
            S_RD_B: begin
               a_reg   <= rd_lo;
               sram_en <= 1'b0;
               state   <= S_MAC;
            end
            S_MAC: begin
               acc <= acc_sum;
               if (k == LAST) begin
                  // Result is loaded from the new sum so it is valid on the first EMIT cycle.
                  k         <= '0;
                  res_valid <= 1'b1;
                  res_data  <= shape(acc_sum);
                  res_row   <= i;
                  res_col   <= j;
                  state     <= S_EMIT;
               end else begin
                  k         <= k + IW'(1);
                  sram_en   <= 1'b1;
                  sram_addr <= word_addr(BASE_A, i, k + IW'(1));
                  state     <= S_RD_A;
               end
            end
            S_EMIT: begin
               if (res_ready) begin
                  acc       <= '0;
                  res_valid <= 1'b0;
                  i         <= i_next;
                  j         <= j_next;
                  if (last_elem) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     sram_en   <= 1'b1;
                     sram_addr <= word_addr(BASE_A, i_next, '0);
                     state     <= S_RD_A;
                  end
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/matmul_engine.md
# matmul_engine

Parametrised N×N unsigned matrix-multiply engine computing C = A × B. It reads both operand matrices from a single-port synchronous SRAM and streams the result elements in row-major order over a valid/ready interface. It sits between the SRAM and the UART text formatter, and supersedes the fixed 4×4 / 8-bit datapath. Operand width, matrix order, SRAM layout and result width are all generalised, and the result path supports backpressure.

## Interface
Parameters:
- N, 4: matrix order; N ≥ 2.
- DW, 8: operand width; only the low DW bits of each SRAM word are used.
- SW, 18: SRAM word width; SW ≥ DW.
- AW, 11: SRAM address width.
- BASE_A, 0: word address of A[0][0]; A is stored row-major.
- BASE_B, 16: word address of B[0][0]; B is stored row-major.
- OW, 18: result width.
- Derived ACC_W = 2·DW + $clog2(N), the accumulator width, which is full precision.

Ports:
- clk, in, 1: clock.
- reset_n, in, 1: synchronous, active-low reset.
- start, in, 1: level-sampled; begins an operation when the engine is idle.
- busy, out, 1: high from the cycle after start is accepted through the DONE state.
- done, out, 1: one-cycle pulse after the last result is accepted.
- sram_en, out, 1: SRAM read enable.
- sram_addr, out, AW: SRAM read address.
- sram_rdata, in, SW: SRAM data, valid one cycle after the address.
- res_valid, out, 1: result element available.
- res_ready, in, 1: consumer accepts the result element.
- res_data, out, OW: value of C[i][j] (see Configuration).
- res_row, out, $clog2(N): index i.
- res_col, out, $clog2(N): index j.

## Operation
- States: IDLE, RD_A, RD_B, MAC, EMIT, DONE.
- IDLE: busy=0, sram_en=0. On start=1, clear i, j, k and acc, then go to RD_A.
- RD_A: sram_en=1, sram_addr = BASE_A + i·N + k. Go to RD_B.
- RD_B: sram_en=1, sram_addr = BASE_B + k·N + j. Register a_reg ← sram_rdata[DW-1:0]. Go to MAC.
- MAC: acc ← acc + a_reg × sram_rdata[DW-1:0].
  - If k = N-1: clear k, go to EMIT.
  - Otherwise: increment k, go to RD_A.
- EMIT:
  - res_valid=1; res_row=i, res_col=j, res_data from acc.
  - All res_* outputs hold stable while res_ready=0.
  - On res_valid & res_ready: clear acc and advance j; when j wraps from N-1 to 0, also advance i.
  - After C[N-1][N-1] is accepted, go to DONE; otherwise go to RD_A.
- DONE: done=1 for one cycle, then go to IDLE.
- Address arithmetic is modulo 2^AW.
- The multiply and accumulate are unsigned and never overflow ACC_W.
- start is ignored while busy=1.
- res_ready is ignored outside EMIT.
- Reset value of every output is 0: busy, done, sram_en, sram_addr, res_valid, res_data, res_row, res_col.
- Reset mid-operation aborts immediately to IDLE and discards any partial acc; no result or done is emitted.

## Timing
- Per k step: exactly 3 cycles (RD_A, RD_B, MAC), with no bubbles.
- Per element: 3N cycles plus at least 1 EMIT cycle; EMIT lasts 1 cycle when res_ready=1.
- Whole matrix with res_ready tied high: N²·(3N+1) cycles from first RD_A to the DONE cycle. For N=4 this is 208 cycles; done follows in the next cycle.
- Accept-to-start latency: start sampled high in IDLE gives RD_A, with busy=1, in the following cycle.
- res_valid rises in the cycle after the final MAC of an element.
- res_valid drops the cycle after the handshake.

## Configuration
- MATMUL_SAT_EN defined:
  - If acc ≥ 2^OW, res_data = {OW{1'b1}}.
  - Otherwise res_data = acc[OW-1:0].
- MATMUL_SAT_EN undefined: res_data = acc[OW-1:0], a silent truncation.
- With the default parameters (ACC_W = OW = 18), the two builds are identical.

## Test plan
- Identity: defaults, A = I, B[r][c] = 4r+c, res_ready=1 → 16 results in order (0,0)…(3,3) with res_data = 4i+j; done pulses exactly once, 209 cycles after start.
- Max operands: all A and B words 0xFF → every res_data = 0x3F804. With OW=16, the truncating build gives 0xF804 and the MATMUL_SAT_EN build gives 0xFFFF.
- Backpressure: res_ready=0 for 5 cycles during the first EMIT → res_valid, res_data, res_row and res_col are stable for those 5 cycles; no element is skipped or duplicated; total runtime is +5 cycles.
- Start while busy: pulse start at cycle 50 of a run → no restart; results are identical to an undisturbed run; a single done.
- Reset mid-op: assert reset_n=0 for 1 cycle during element (1,2) → all outputs 0 in the next cycle. A fresh start then produces the full correct 16-element sequence from (0,0).
- Non-default geometry: N=3, DW=4, BASE_A=100, BASE_B=200, random operands → 9 results matching the reference model; sram_addr stays within 100–108 and 200–208.
